// File: rtl/zap_mac_sequencer_if.sv
// Shift-stage <-> MAC sequencer bus: operands, handshake and the shared multiplier port.
interface zap_mac_sequencer_if;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned HALF_W = 16;

  // Shift-stage control
  logic              i_clear;
  logic              i_hold;
  logic              i_start;

  // Instruction operands
  logic [DATA_W-1:0] i_rm;
  logic [DATA_W-1:0] i_rs;
  logic [DATA_W-1:0] i_rn;

  // Shared 16x16 multiplier
  logic [HALF_W-1:0] o_mul_a;
  logic [HALF_W-1:0] o_mul_b;
  logic [DATA_W-1:0] i_mul_p;

  // Result and status
  logic [DATA_W-1:0] o_rd;
  logic              o_busy;
  logic              o_done;

  // Shift stage plus the multiplier product path
  modport master (
    output i_clear, i_hold, i_start,
    output i_rm, i_rs, i_rn,
    output i_mul_p,
    input  o_mul_a, o_mul_b,
    input  o_rd, o_busy, o_done
  );

  // Sequencer side
  modport slave (
    input  i_clear, i_hold, i_start,
    input  i_rm, i_rs, i_rn,
    input  i_mul_p,
    output o_mul_a, o_mul_b,
    output o_rd, o_busy, o_done
  );
endinterface

// File: rtl/zap_mac_sequencer.sv
// Multi-cycle MLA/MUL controller: rd = (rm*rs + rn) mod 2^32 built from up to
// three 16x16 partial products on a shared multiplier.
module zap_mac_sequencer #(
  parameter bit ZERO_SKIP = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  zap_mac_sequencer_if.slave    bus
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned HALF_W = 16;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_P0   = 3'd1,
    S_P1   = 3'd2,
    S_P2   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t              state_q;
  state_t              state_d;

  logic [DATA_W-1:0]   acc_q;
  logic [DATA_W-1:0]   acc_d;
  logic [DATA_W-1:0]   rm_q;
  logic [DATA_W-1:0]   rm_d;
  logic [DATA_W-1:0]   rs_q;
  logic [DATA_W-1:0]   rs_d;
  logic [DATA_W-1:0]   rd_q;
  logic                done_q;

  logic [HALF_W-1:0]   mul_a_c;
  logic [HALF_W-1:0]   mul_b_c;
  logic                busy_c;

  logic [HALF_W-1:0]   a0;
  logic [HALF_W-1:0]   a1;
  logic [HALF_W-1:0]   b0;
  logic [HALF_W-1:0]   b1;
  logic                a1_zero;
  logic                b1_zero;
  logic [DATA_W-1:0]   prod_hi;

  // Operand halves and the zero tests that drive the skip chain
  assign a0      = rm_q[HALF_W-1:0];
  assign a1      = rm_q[DATA_W-1:HALF_W];
  assign b0      = rs_q[HALF_W-1:0];
  assign b1      = rs_q[DATA_W-1:HALF_W];
  assign a1_zero = (a1 == HALF_W'(0));
  assign b1_zero = (b1 == HALF_W'(0));

  // Cross products land at bit 16; anything above bit 31 is discarded
  assign prod_hi = {bus.i_mul_p[HALF_W-1:0], HALF_W'(0)};

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: clear wins, a dropped start aborts, otherwise walk the skip chain
  always_comb begin
    state_d = state_q;
    if (bus.i_clear) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.i_start) state_d = S_P0;
        end
        S_P0: begin
          if (!bus.i_start)                 state_d = S_IDLE;
          else if (!ZERO_SKIP || !b1_zero)  state_d = S_P1;
          else if (!a1_zero)                state_d = S_P2;
          else                              state_d = S_DONE;
        end
        S_P1: begin
          if (!bus.i_start)                 state_d = S_IDLE;
          else if (ZERO_SKIP && a1_zero)    state_d = S_DONE;
          else                              state_d = S_P2;
        end
        S_P2: begin
          if (!bus.i_start)                 state_d = S_IDLE;
          else                              state_d = S_DONE;
        end
        S_DONE: begin
          if (!bus.i_hold)                  state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs and datapath next values: multiplier driven only in P0-P2
  always_comb begin
    mul_a_c = HALF_W'(0);
    mul_b_c = HALF_W'(0);
    busy_c  = 1'b0;
    acc_d   = acc_q;
    rm_d    = rm_q;
    rs_d    = rs_q;
    if (!bus.i_clear) begin
      unique case (state_q)
        S_IDLE: begin
          busy_c = bus.i_start;
          if (bus.i_start) begin
            rm_d  = bus.i_rm;
            rs_d  = bus.i_rs;
            acc_d = bus.i_rn;
          end
        end
        S_P0: begin
          busy_c  = 1'b1;
          mul_a_c = a0;
          mul_b_c = b0;
          acc_d   = acc_q + bus.i_mul_p;
        end
        S_P1: begin
          busy_c  = 1'b1;
          mul_a_c = a0;
          mul_b_c = b1;
          acc_d   = acc_q + prod_hi;
        end
        S_P2: begin
          busy_c  = 1'b1;
          mul_a_c = a1;
          mul_b_c = b0;
          acc_d   = acc_q + prod_hi;
        end
        S_DONE: begin
          busy_c = 1'b0;
        end
        default: begin
          busy_c = 1'b0;
        end
      endcase
    end
  end

  // Datapath registers; result and done are loaded on entry to DONE and held there
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      acc_q  <= DATA_W'(0);
      rm_q   <= DATA_W'(0);
      rs_q   <= DATA_W'(0);
      rd_q   <= DATA_W'(0);
      done_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      rm_q   <= rm_d;
      rs_q   <= rs_d;
      done_q <= (state_d == S_DONE);
      rd_q   <= (state_d == S_DONE) ? acc_d : DATA_W'(0);
    end
  end

  assign bus.o_mul_a = mul_a_c;
  assign bus.o_mul_b = mul_b_c;
  assign bus.o_busy  = busy_c;
  assign bus.o_done  = done_q;
  assign bus.o_rd    = rd_q;

endmodule

// File: tb/tb_zap_mac_sequencer.sv
// Directed bench: one sequencer with zero-skip disabled, one with the default.
module tb_zap_mac_sequencer;

  logic        clk;
  logic        rst;
  logic        clear;
  logic        hold;
  logic        start0;
  logic        start1;
  logic [31:0] rm;
  logic [31:0] rs;
  logic [31:0] rn;

  int total;
  int bad;

  zap_mac_sequencer_if bus0 ();
  zap_mac_sequencer_if bus1 ();

  assign bus0.i_clear = clear;
  assign bus0.i_hold  = hold;
  assign bus0.i_start = start0;
  assign bus0.i_rm    = rm;
  assign bus0.i_rs    = rs;
  assign bus0.i_rn    = rn;
  assign bus0.i_mul_p = 32'(bus0.o_mul_a) * 32'(bus0.o_mul_b);

  assign bus1.i_clear = clear;
  assign bus1.i_hold  = hold;
  assign bus1.i_start = start1;
  assign bus1.i_rm    = rm;
  assign bus1.i_rs    = rs;
  assign bus1.i_rn    = rn;
  assign bus1.i_mul_p = 32'(bus1.o_mul_a) * 32'(bus1.o_mul_b);

  zap_mac_sequencer #(.ZERO_SKIP(1'b0)) dut0 (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus0.slave)
  );

  zap_mac_sequencer #(.ZERO_SKIP(1'b1)) dut1 (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge, then let combinational paths settle
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    rst    = 1'b1;
    clear  = 1'b0;
    hold   = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    rm     = 32'h0;
    rs     = 32'h0;
    rn     = 32'h0;

    // Reset
    tick(); tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_busy",  32'(bus1.o_busy),  32'd0);
    chk("rst_done",  32'(bus1.o_done),  32'd0);
    chk("rst_rd",    bus1.o_rd,         32'd0);
    chk("rst_mul_a", 32'(bus1.o_mul_a), 32'd0);
    chk("rst_mul_b", 32'(bus1.o_mul_b), 32'd0);
    chk("rst_rd0",   bus0.o_rd,         32'd0);

    // 3*5+7 with every partial product run
    tick();
    rm = 32'd3; rs = 32'd5; rn = 32'd7; start0 = 1'b1;
    #1;
    chk("full_idle_busy", 32'(bus0.o_busy), 32'd1);
    chk("full_idle_mula", 32'(bus0.o_mul_a), 32'd0);
    tick();
    chk("full_p0_busy", 32'(bus0.o_busy), 32'd1);
    chk("full_p0_ab", {bus0.o_mul_a, bus0.o_mul_b}, {16'd3, 16'd5});
    tick();
    chk("full_p1_busy", 32'(bus0.o_busy), 32'd1);
    chk("full_p1_ab", {bus0.o_mul_a, bus0.o_mul_b}, {16'd3, 16'd0});
    tick();
    chk("full_p2_busy", 32'(bus0.o_busy), 32'd1);
    chk("full_p2_ab", {bus0.o_mul_a, bus0.o_mul_b}, {16'd0, 16'd5});
    tick();
    chk("full_done_busy", 32'(bus0.o_busy), 32'd0);
    chk("full_done",      32'(bus0.o_done), 32'd1);
    chk("full_rd",        bus0.o_rd,        32'd22);
    chk("full_done_ab", {bus0.o_mul_a, bus0.o_mul_b}, 32'd0);
    start0 = 1'b0;
    tick();
    chk("full_idle_done", 32'(bus0.o_done), 32'd0);
    chk("full_idle_busy2", 32'(bus0.o_busy), 32'd0);

    // Same operands with zero skip: P0 then DONE
    rm = 32'd3; rs = 32'd5; rn = 32'd7; start1 = 1'b1;
    #1;
    chk("skip_idle_busy", 32'(bus1.o_busy), 32'd1);
    tick();
    chk("skip_p0_busy", 32'(bus1.o_busy), 32'd1);
    chk("skip_p0_ab", {bus1.o_mul_a, bus1.o_mul_b}, {16'd3, 16'd5});
    tick();
    chk("skip_done_busy", 32'(bus1.o_busy), 32'd0);
    chk("skip_done",      32'(bus1.o_done), 32'd1);
    chk("skip_rd",        bus1.o_rd,        32'd22);
    start1 = 1'b0;
    tick();
    chk("skip_idle_done", 32'(bus1.o_done), 32'd0);

    // All three products with non-zero upper halves
    rm = 32'h0001_0002; rs = 32'h0003_0004; rn = 32'd1; start1 = 1'b1;
    tick();
    chk("mix_p0_ab", {bus1.o_mul_a, bus1.o_mul_b}, {16'd2, 16'd4});
    tick();
    chk("mix_p1_ab", {bus1.o_mul_a, bus1.o_mul_b}, {16'd2, 16'd3});
    tick();
    chk("mix_p2_ab", {bus1.o_mul_a, bus1.o_mul_b}, {16'd1, 16'd4});
    tick();
    chk("mix_done", 32'(bus1.o_done), 32'd1);
    chk("mix_rd",   bus1.o_rd,        32'h000A_0009);
    start1 = 1'b0;
    tick();

    // Wrap-around: 0xFFFFFFFF squared
    rm = 32'hFFFF_FFFF; rs = 32'hFFFF_FFFF; rn = 32'd0; start1 = 1'b1;
    tick(); tick(); tick(); tick();
    chk("wrap_done", 32'(bus1.o_done), 32'd1);
    chk("wrap_rd",   bus1.o_rd,        32'h0000_0001);
    start1 = 1'b0;
    tick();

    // Clear in P1 flushes the instruction
    rm = 32'h0001_0002; rs = 32'h0003_0004; rn = 32'd1; start1 = 1'b1;
    tick();
    tick();
    chk("clr_p1_ab", {bus1.o_mul_a, bus1.o_mul_b}, {16'd2, 16'd3});
    clear = 1'b1; start1 = 1'b0;
    #1;
    chk("clr_busy",  32'(bus1.o_busy), 32'd0);
    chk("clr_ab",    {bus1.o_mul_a, bus1.o_mul_b}, 32'd0);
    tick();
    clear = 1'b0;
    #1;
    chk("clr_idle_busy", 32'(bus1.o_busy), 32'd0);
    chk("clr_idle_done", 32'(bus1.o_done), 32'd0);
    chk("clr_idle_ab",   {bus1.o_mul_a, bus1.o_mul_b}, 32'd0);
    tick(); tick(); tick();
    chk("clr_no_done", 32'(bus1.o_done), 32'd0);

    // Clear and start together in IDLE: nothing captured
    clear = 1'b1; start1 = 1'b1;
    #1;
    chk("clrst_busy", 32'(bus1.o_busy), 32'd0);
    tick();
    clear = 1'b0; start1 = 1'b0;
    #1;
    chk("clrst_idle_busy", 32'(bus1.o_busy), 32'd0);
    chk("clrst_idle_ab",   {bus1.o_mul_a, bus1.o_mul_b}, 32'd0);

    // Start dropped mid-sequence aborts without presenting a result
    rm = 32'h0001_0002; rs = 32'h0003_0004; rn = 32'd1; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tick();
    chk("abort_busy", 32'(bus1.o_busy), 32'd0);
    chk("abort_done", 32'(bus1.o_done), 32'd0);
    tick();
    chk("abort_done2", 32'(bus1.o_done), 32'd0);

    // Hold keeps DONE and the result stable
    rm = 32'd3; rs = 32'd5; rn = 32'd7; start1 = 1'b1;
    tick();
    tick();
    hold = 1'b1; start1 = 1'b0;
    #1;
    chk("hold_done_c1", 32'(bus1.o_done), 32'd1);
    chk("hold_rd_c1",   bus1.o_rd,        32'd22);
    tick();
    chk("hold_done_c2", 32'(bus1.o_done), 32'd1);
    chk("hold_rd_c2",   bus1.o_rd,        32'd22);
    tick();
    chk("hold_done_c3", 32'(bus1.o_done), 32'd1);
    chk("hold_rd_c3",   bus1.o_rd,        32'd22);
    tick();
    chk("hold_done_c4", 32'(bus1.o_done), 32'd1);
    chk("hold_busy_c4", 32'(bus1.o_busy), 32'd0);
    hold = 1'b0;
    tick();
    chk("hold_release", 32'(bus1.o_done), 32'd0);

    // Back-to-back: sum wraps to zero, next instruction starts right after DONE
    rm = 32'd2; rs = 32'h4000_0000; rn = 32'h8000_0000; start1 = 1'b1;
    tick();
    chk("b2b_p0_ab", {bus1.o_mul_a, bus1.o_mul_b}, {16'd2, 16'd0});
    tick();
    chk("b2b_p1_ab", {bus1.o_mul_a, bus1.o_mul_b}, {16'd2, 16'h4000});
    tick();
    chk("b2b_done",      32'(bus1.o_done), 32'd1);
    chk("b2b_rd",        bus1.o_rd,        32'd0);
    chk("b2b_done_busy", 32'(bus1.o_busy), 32'd0);
    rm = 32'd3; rs = 32'd5; rn = 32'd7;
    tick();
    chk("b2b_idle_busy", 32'(bus1.o_busy), 32'd1);
    chk("b2b_idle_done", 32'(bus1.o_done), 32'd0);
    tick();
    chk("b2b2_p0_ab", {bus1.o_mul_a, bus1.o_mul_b}, {16'd3, 16'd5});
    tick();
    chk("b2b2_rd", bus1.o_rd, 32'd22);
    start1 = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
